led_display_pattern_gen_stream: RTL
===================================

Name: led_display_pattern_gen_stream

Overview:
- Parametrised successor to the row-based test pattern generator.
- Streams one pixel pair per beat over a valid/ready interface: top half row, plus the matching bottom half row, for HUB75-style 1/(NUM_ROW_PIXELS/2) scan panels.
- Supports configurable panel size, colour depth and frame-synchronous mode switching, plus an optional animated scroll mode.
- Sits between mode control and the display driver PHY / framebuffer writer.

Parameters:
- SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz (informational only, no timing derived).
- NUM_ROW_PIXELS, 32, panel rows; power of two, >=4.
- NUM_COL_PIXELS, 64, panel columns; power of two, >=8.
- COLOR_BITS, 4, bits per colour channel; 1..8, <= log2(NUM_COL_PIXELS).
- Derived: SCAN_ROWS = NUM_ROW_PIXELS/2; CW = log2(NUM_COL_PIXELS); RW = log2(SCAN_ROWS); M = 2^COLOR_BITS-1.

Ports:
- clk_in  input  1  system clock, all logic on rising edge
- n_reset_in  input  1  asynchronous active-low reset
- mode_in  input  4  pattern select; sampled only at frame boundaries
- pix_top_out  output  3*COLOR_BITS  {R,G,B} for pixel (x=col, y=row)
- pix_bot_out  output  3*COLOR_BITS  {R,G,B} for pixel (x=col, y=row+SCAN_ROWS)
- col_out  output  CW  column index of current beat
- row_address_out  output  RW  scan row address of current beat
- sof_out  output  1  high on beat col=0,row=0
- eol_out  output  1  high on beat col=NUM_COL_PIXELS-1
- eof_out  output  1  high on last beat of frame (last col, row SCAN_ROWS-1)
- pix_valid_out  output  1  beat valid
- pix_ready_in  input  1  downstream ready

Behaviour:
- Reset (async assert, sync release): all outputs 0, col/row counters 0, latched mode 0, frame counter 0.
- First rising edge after release: latch mode_in, load beat (0,0), pix_valid_out=1. Valid never drops after that except on reset.
- All outputs are registered.
- Transfer occurs when pix_valid_out && pix_ready_in. While valid && !ready, every output holds stable.
- On transfer the next beat is loaded on the same edge (zero bubble); throughput is 1 beat/cycle with ready tied high.
- Order: col 0..NUM_COL_PIXELS-1 within a row; then row_address++.
- After col=last, row=SCAN_ROWS-1 (eof beat) transfers: wrap to (0,0), frame_cnt++ mod NUM_COL_PIXELS, and latch mode_in on that same edge.
- Mode changes mid-frame have no effect until the next frame. No partial frames are ever emitted.
- Patterns, where x = col and y = absolute pixel row:
  - 0: all 0.
  - 1: R=M. 2: G=M. 3: B=M. 4: R=G=B=M.
  - 5: colour bars; b = x[CW-1:CW-3]; R=b[0]?M:0, G=b[1]?M:0, B=b[2]?M:0.
  - 6: gradient; R=G=B = x[CW-1:CW-COLOR_BITS].
  - 7: checkerboard; R=G=B = (x[0]^y[0]) ? M : 0.
  - 8: scroll; as mode 5 with x replaced by (x+frame_cnt) mod NUM_COL_PIXELS.
  - 9-15: treated as 0.
- Flags are computed from the loaded beat's counters and hold with the data.
- Reset mid-frame: immediate return to reset values. The next frame restarts at (0,0) with frame_cnt=0.

Optional Feature:
- Macro LED_PTG_SCROLL_EN.
- Defined: frame counter present; mode 8 scrolls the bars by one column per frame.
- Undefined: no frame counter logic; mode 8 behaves as mode 0 (all zero).

Test Plan:
- Reset, mode_in=4, ready=1 -> valid rises on 1st edge; 1024 consecutive beats with R=G=B=15. sof on beat 0, eol every 64th beat, eof on beat 1023, row_address 0..15 then wraps to 0.
- Mode 5, ready=1 -> col 0-7 pix 0x000, col 8-15 R=15 (0xF00), col 56-63 0xFFF; top and bottom identical.
- Mode 7 -> beat (col=1,row=0) top=0xFFF, bot=0xFFF (y=16, y[0]=0); beat (col=1,row=1) top=0x000.
- Change mode_in 1->2 at beat 300 -> remaining beats of frame stay 0xF00; first beat after eof transfer is 0x0F0 with sof=1.
- Random ready toggling (~50%) in mode 6 -> outputs stable while stalled; no beat lost or duplicated (scoreboard col/row sequence); gradient value = col>>2.
- Mode 8 with LED_PTG_SCROLL_EN -> frame 1, col 0 equals frame 0, col 1. Without macro -> all beats 0. Async reset asserted mid-row -> outputs 0 immediately; restart at (0,0).

Source files
------------

// File: rtl/led_display_pattern_gen_stream.sv
// led_display_pattern_gen_stream: streams HUB75 top/bottom pixel pairs over valid/ready.
// Define LED_PTG_SCROLL_EN to add the frame counter and the scrolling bars in mode 8.
module led_display_pattern_gen_stream #(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int COLOR_BITS     = 4
) (
    input  logic                                  clk_in,
    input  logic                                  n_reset_in,
    input  logic [3:0]                            mode_in,
    output logic [3*COLOR_BITS-1:0]               pix_top_out,
    output logic [3*COLOR_BITS-1:0]               pix_bot_out,
    output logic [$clog2(NUM_COL_PIXELS)-1:0]     col_out,
    output logic [$clog2(NUM_ROW_PIXELS/2)-1:0]   row_address_out,
    output logic                                  sof_out,
    output logic                                  eol_out,
    output logic                                  eof_out,
    output logic                                  pix_valid_out,
    input  logic                                  pix_ready_in
);
    localparam int CW = $clog2(NUM_COL_PIXELS);
    localparam int RW = $clog2(NUM_ROW_PIXELS / 2);
    localparam logic [COLOR_BITS-1:0] M = '1;
    localparam logic [COLOR_BITS-1:0] Z = '0;

    if (SYS_CLK_FREQ <= 0 || NUM_ROW_PIXELS < 4 || (NUM_ROW_PIXELS & (NUM_ROW_PIXELS - 1)) != 0 ||
        NUM_COL_PIXELS < 8 || (NUM_COL_PIXELS & (NUM_COL_PIXELS - 1)) != 0 ||
        COLOR_BITS < 1 || COLOR_BITS > 8 || COLOR_BITS > CW) begin : g_bad_param
        $error("led_display_pattern_gen_stream: illegal parameter set");
    end

    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_row;
    logic [3:0]              r_mode;
    logic                    r_valid;
    logic [3*COLOR_BITS-1:0] r_top;
    logic [3*COLOR_BITS-1:0] r_bot;
    logic                    r_sof;
    logic                    r_eol;
    logic                    r_eof;

    logic                    w_load;
    logic                    w_wrap;
    logic [CW-1:0]           w_nxt_col;
    logic [RW-1:0]           w_nxt_row;
    logic [3:0]              w_nxt_mode;
    logic [2:0]              w_b;
    logic [COLOR_BITS-1:0]   w_g;
    logic                    w_chk;
    logic [3*COLOR_BITS-1:0] w_pix;

    function automatic logic [3*COLOR_BITS-1:0] f_bars(input logic [2:0] b);
        return {b[0] ? M : Z, b[1] ? M : Z, b[2] ? M : Z};
    endfunction

    assign w_load     = !r_valid || pix_ready_in;
    assign w_wrap     = r_valid && (&r_col) && (&r_row);
    assign w_nxt_col  = r_valid ? r_col + CW'(1) : '0;
    assign w_nxt_row  = !r_valid ? '0 : ((&r_col) ? r_row + RW'(1) : r_row);
    assign w_nxt_mode = (!r_valid || w_wrap) ? mode_in : r_mode;
    assign w_b        = w_nxt_col[CW-1:CW-3];
    assign w_g        = w_nxt_col[CW-1:CW-COLOR_BITS];
    // Bottom row is row+SCAN_ROWS (even offset), so its parity matches the top row.
    assign w_chk      = w_nxt_col[0] ^ w_nxt_row[0];

`ifdef LED_PTG_SCROLL_EN
    logic [CW-1:0] r_frame;
    logic [CW-1:0] w_nxt_frame;
    logic [2:0]    w_bs;
    assign w_nxt_frame = w_wrap ? r_frame + CW'(1) : r_frame;
    assign w_bs        = 3'((w_nxt_col + w_nxt_frame) >> (CW - 3));
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) r_frame <= '0;
        else if (w_load) r_frame <= w_nxt_frame;
    end
`endif

    always_comb begin
        w_pix = '0;
        case (w_nxt_mode)
            4'd1: w_pix = {M, Z, Z};
            4'd2: w_pix = {Z, M, Z};
            4'd3: w_pix = {Z, Z, M};
            4'd4: w_pix = {M, M, M};
            4'd5: w_pix = f_bars(w_b);
            4'd6: w_pix = {w_g, w_g, w_g};
            4'd7: w_pix = w_chk ? {M, M, M} : '0;
`ifdef LED_PTG_SCROLL_EN
            4'd8: w_pix = f_bars(w_bs);
`endif
            default: w_pix = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_col   <= '0;
            r_row   <= '0;
            r_mode  <= '0;
            r_valid <= 1'b0;
            r_top   <= '0;
            r_bot   <= '0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (w_load) begin
            r_col   <= w_nxt_col;
            r_row   <= w_nxt_row;
            r_mode  <= w_nxt_mode;
            r_valid <= 1'b1;
            r_top   <= w_pix;
            r_bot   <= w_pix;
            r_sof   <= (w_nxt_col == '0) && (w_nxt_row == '0);
            r_eol   <= &w_nxt_col;
            r_eof   <= (&w_nxt_col) && (&w_nxt_row);
        end
    end

    assign pix_top_out     = r_top;
    assign pix_bot_out     = r_bot;
    assign col_out         = r_col;
    assign row_address_out = r_row;
    assign sof_out         = r_sof;
    assign eol_out         = r_eol;
    assign eof_out         = r_eof;
    assign pix_valid_out   = r_valid;
endmodule
